// File: rtl/delapan_bit_bagi_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and iteration-counter sizing.
package delapan_bit_bagi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/delapan_bit_bagi_step.sv
// One restoring-division step: compare the (W+1)-bit partial remainder
// against the divisor, subtract when it fits, and emit the quotient bit.
module delapan_bit_bagi_step
  import delapan_bit_bagi_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             qbit
);

  always_comb begin
    qbit = (t >= {1'b0, divisor});
    // t < 2*divisor on entry, so the difference always fits in WIDTH bits
    rem  = qbit ? WIDTH'(t - {1'b0, divisor}) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/delapan_bit_bagi.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, enable/done level handshake shared with the multiplier.
module delapan_bit_bagi
  import delapan_bit_bagi_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     r,
  output logic                 overflow,
  output logic                 done_bagi
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-2:0] quo_w;
  logic [WIDTH-1:0] dvd_lo;
  logic [WIDTH-1:0] dvs;
  logic             ovf_pend;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  delapan_bit_bagi_step #(.WIDTH(WIDTH)) bagi_step (
    .t       ({rem_w, dvd_lo[WIDTH-1]}),
    .divisor (dvs),
    .rem     (step_rem),
    .qbit    (step_qbit)
  );

  // Overflow is decided at capture but reported one edge later through CALC,
  // so done rises after edge 1 rather than on the capture edge itself.
  // The working quotient holds W-1 bits; the final bit is appended on load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_w     <= '0;
      quo_w     <= '0;
      dvd_lo    <= '0;
      dvs       <= '0;
      ovf_pend  <= 1'b0;
      q         <= '0;
      r         <= '0;
      overflow  <= 1'b0;
      done_bagi <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_bagi <= 1'b0;
          if (enable) begin
            dvs      <= divisor;
            dvd_lo   <= dividend[WIDTH-1:0];
            quo_w    <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            state    <= CALC;
            if (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              ovf_pend <= 1'b1;
              rem_w    <= '0;
            end else begin
              ovf_pend <= 1'b0;
              rem_w    <= dividend[2*WIDTH-1:WIDTH];
            end
          end
        end
        CALC: begin
          if (ovf_pend) begin
            ovf_pend  <= 1'b0;
            q         <= '1;
            r         <= '0;
            overflow  <= 1'b1;
            done_bagi <= 1'b1;
            state     <= DONE;
          end else begin
            rem_w  <= step_rem;
            quo_w  <= {quo_w[WIDTH-3:0], step_qbit};
            dvd_lo <= {dvd_lo[WIDTH-2:0], 1'b0};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              q         <= {quo_w, step_qbit};
              r         <= step_rem;
              done_bagi <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            done_bagi <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delapan_bit_bagi.sv
// Scoreboard bench for delapan_bit_bagi: stimulus pushes expected results from
// an arithmetic reference model, a monitor pops them when done_bagi rises.
module tb_delapan_bit_bagi;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        overflow;
  logic        done_bagi;

  delapan_bit_bagi #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .dividend  (dividend),
    .divisor   (divisor),
    .q         (q),
    .r         (r),
    .overflow  (overflow),
    .done_bagi (done_bagi)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned ovf;
    int unsigned lat;
    int unsigned cap;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned edge_cnt    = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned dd, input int unsigned dv,
                                 input int unsigned cap);
    exp_t e;
    e.cap = cap;
    if (dv == 0 || dd / 256 >= dv) begin
      e.q = 255; e.r = 0; e.ovf = 1; e.lat = 1;
    end else begin
      e.q = dd / dv; e.r = dd % dv; e.ovf = 0; e.lat = 8;
    end
    return e;
  endfunction

  // Monitor: compare whenever a result is presented
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (done_bagi && !prev_done) begin
      check("scoreboard_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("q", q, mon_e.q);
        check("r", r, mon_e.r);
        check("overflow", overflow, mon_e.ovf);
        check("done_latency", edge_cnt - mon_e.cap, mon_e.lat);
      end
    end
    prev_done <= done_bagi;
  end

  // Called at a negedge with the DUT idle; returns at a negedge with DUT idle.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input int unsigned hold);
    exp_t e;
    int unsigned n;
    dividend = dd;
    divisor  = dv;
    enable   = 1'b1;
    e = model(dd, dv, edge_cnt + 1);
    sb.push_back(e);
    n = 0;
    while (!done_bagi && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", done_bagi, 1);
    for (int unsigned i = 0; i < hold; i++) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clock);
      check("hold_done", done_bagi, 1);
      check("hold_q", q, e.q);
      check("hold_r", r, e.r);
    end
    enable = 1'b0;
    @(negedge clock);
    check("drop_done", done_bagi, 0);
    check("idle_q", q, e.q);
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done_bagi, 0);

    // release and capture on the very first edge after release
    reset = 1'b1;
    run_op(16'd50000, 8'd200, 5);
    run_op(16'd37247, 8'd170, 1);
    run_op(16'd1234, 8'd0, 2);
    run_op(16'hAA00, 8'hAA, 0);

    // reset in the middle of CALC; the aborted operation must never report
    dividend = 16'd60000;
    divisor  = 8'd250;
    enable   = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_ovf", overflow, 0);
    check("abort_done", done_bagi, 0);
    repeat (3) @(negedge clock);
    check("abort_still_idle", done_bagi, 0);
    reset = 1'b1;
    run_op(16'd1000, 8'd7, 2);

    for (int unsigned k = 0; k < 150; k++) begin
      logic [15:0] dd;
      logic [7:0]  dv;
      dv = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) dv = 8'd0;
      if ($urandom_range(0, 2) != 0 && dv != 0)
        dd = 16'($urandom_range(0, int'(dv) * 256 - 1));
      else
        dd = 16'($urandom);
      run_op(dd, dv, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
